// File: rtl/note_player.sv
// Note sequence memory plus square-wave tone generator for the music controller.
// Build option NOTE_GAP_EN: insert GAP_CYCLES of silence at every note change during playback.
module note_player #(
  parameter int unsigned HALF_W     = 17,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_note_i,
  input  logic       ld_play_i,
  input  logic [3:0] note_counter_i,
  input  logic [3:0] note_in_i,
  output logic       audio_out_o,
  output logic [3:0] cur_note_o,
  output logic [3:0] wr_ptr_o,
  output logic       mem_full_o
);

  // Half period minus one, in clk cycles; rests map to zero.
  function automatic logic [HALF_W-1:0] tone_reload(input logic [3:0] code);
    int unsigned hp;
    case (code)
      4'd1:    hp = 95555;
      4'd2:    hp = 90194;
      4'd3:    hp = 85132;
      4'd4:    hp = 80353;
      4'd5:    hp = 75843;
      4'd6:    hp = 71586;
      4'd7:    hp = 67569;
      4'd8:    hp = 63776;
      4'd9:    hp = 60197;
      4'd10:   hp = 56818;
      4'd11:   hp = 53630;
      4'd12:   hp = 50620;
      default: hp = 1;
    endcase
    return HALF_W'(hp - 1);
  endfunction

  function automatic logic is_pitch(input logic [3:0] code);
    return (code != 4'd0) && (code <= 4'd12);
  endfunction

  logic [3:0] mem_q [16];
  logic [3:0] wr_ptr_q;
  logic       mem_full_q;
  logic       ld_note_q;
  logic [3:0] cur_note_q;
  logic [3:0] prev_note_q;
  logic       wr_en;

  assign wr_en = ld_note_i & ~ld_note_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      mem_full_q  <= 1'b0;
      ld_note_q   <= 1'b0;
      cur_note_q  <= '0;
      prev_note_q <= '0;
    end else begin
      ld_note_q <= ld_note_i;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= note_in_i;
        wr_ptr_q        <= wr_ptr_q + 4'd1;
        if (wr_ptr_q == 4'hf) mem_full_q <= 1'b1;
      end
      // Same-address read returns the pre-write contents.
      cur_note_q  <= ld_play_i ? mem_q[note_counter_i] : 4'd0;
      prev_note_q <= cur_note_q;
    end
  end

`ifdef NOTE_GAP_EN
  typedef enum logic [1:0] {StIdle, StTone, StGap} state_e;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);
  logic [GapW-1:0] gap_q, gap_d;
`else
  typedef enum logic [0:0] {StIdle, StTone} state_e;
`endif

  state_e            state_q, state_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              audio_q, audio_d;
  logic              note_chg;
  logic              cur_pitch;
  logic [HALF_W-1:0] reload;

  assign note_chg  = cur_note_q != prev_note_q;
  assign cur_pitch = is_pitch(cur_note_q);
  assign reload    = tone_reload(cur_note_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    audio_d = audio_q;
`ifdef NOTE_GAP_EN
    gap_d   = gap_q;
    if (!ld_play_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      audio_d = 1'b0;
      gap_d   = '0;
    end else if (note_chg) begin
      // Any change, even back to the same pitch across a rest, restarts the silence.
      state_d = StGap;
      cnt_d   = '0;
      audio_d = 1'b0;
      gap_d   = GapLoad;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cur_pitch) begin
            state_d = StTone;
            cnt_d   = reload;
            audio_d = 1'b0;
          end
        end
        StTone: begin
          if (!cur_pitch) begin
            state_d = StIdle;
            cnt_d   = '0;
            audio_d = 1'b0;
          end else if (cnt_q == '0) begin
            cnt_d   = reload;
            audio_d = ~audio_q;
          end else begin
            cnt_d = cnt_q - HALF_W'(1);
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_d = cur_pitch ? StTone : StIdle;
            cnt_d   = cur_pitch ? reload : '0;
            audio_d = 1'b0;
          end else begin
            gap_d = gap_q - GapW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          audio_d = 1'b0;
        end
      endcase
    end
`else
    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        audio_d = 1'b0;
        if (ld_play_i && cur_pitch) begin
          state_d = StTone;
          cnt_d   = reload;
        end
      end
      StTone: begin
        if (!ld_play_i || !cur_pitch) begin
          state_d = StIdle;
          cnt_d   = '0;
          audio_d = 1'b0;
        end else if (note_chg) begin
          cnt_d   = reload;
          audio_d = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d   = reload;
          audio_d = ~audio_q;
        end else begin
          cnt_d = cnt_q - HALF_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        audio_d = 1'b0;
      end
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      audio_q <= 1'b0;
`ifdef NOTE_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      audio_q <= audio_d;
`ifdef NOTE_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign audio_out_o = audio_q;
  assign cur_note_o  = cur_note_q;
  assign wr_ptr_o    = wr_ptr_q;
  assign mem_full_o  = mem_full_q;

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Datapath end of the music control interface: consumes ld_note, ld_play and note_counter from the control FSM.
- Stores a 16-entry note sequence entered from switches. During playback, reads the entry selected by note_counter and drives a square-wave audio output at that note's pitch.
- Sits between the control FSM and the audio codec/speaker pin.

Parameters:
- HALF_W, 17, width of the tone half-period counter (fits 95555).
- GAP_CYCLES, 2500000, silence length in clk cycles inserted at each note change (used only with NOTE_GAP_EN; 50 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-low
- ld_note  input  1  load strobe from control; a level, may be held many cycles
- ld_play  input  1  high while playback is active
- note_counter  input  4  playback index from control
- note_in  input  4  note code from switches
- audio_out  output  1  square-wave audio
- cur_note  output  4  registered note code currently sounding
- wr_ptr  output  4  next memory write address
- mem_full  output  1  sticky; set once 16 notes have been written

Behaviour:
- Reset (reset==0 at posedge clk):
  - all 16 mem entries = 0; wr_ptr = 0; mem_full = 0; cur_note = 0; audio_out = 0.
  - tone counter = 0; ld_note_q = 0; gap counter = 0.
  - Reset mid-playback or mid-gap aborts immediately.
- Note codes:
  - 0 = rest. 13-15 = rest.
  - 1-12 = C4, C#4, D4, D#4, E4, F4, F#4, G4, G#4, A4, A#4, B4.
  - Half-period table (clk cycles), from round(25e6/f): 95555, 90194, 85132, 80353, 75843, 71586, 67569, 63776, 60197, 56818, 53630, 50620.
- Load:
  - ld_note_q is ld_note delayed one cycle. A write occurs only on the rising edge (ld_note & ~ld_note_q): mem[wr_ptr] <= note_in; wr_ptr <= wr_ptr+1.
  - wr_ptr wraps 15 -> 0 and overwrites the oldest entry. mem_full is set on the write at wr_ptr==15 and stays set until reset.
  - Holding ld_note high writes exactly once.
- Playback read:
  - While ld_play==1, cur_note <= mem[note_counter] every cycle (1-cycle latency from a note_counter change).
  - While ld_play==0, cur_note <= 0.
  - If a write and a read hit the same address in the same cycle, the read returns the old data.
- Tone generator FSM, states IDLE, TONE, GAP:
  - IDLE: audio_out = 0; counter = 0. Enter TONE when ld_play==1 and cur_note is a pitch code. On entering TONE, counter loads half-period-1 and audio_out = 0.
  - TONE: counter decrements each cycle. At 0, audio_out toggles and counter reloads half-period-1, giving a period of 2*half-period cycles.
  - When cur_note changes to another pitch (detected against the previous cur_note), counter reloads, audio_out = 0, and the new pitch starts. With NOTE_GAP_EN the FSM goes to GAP instead.
  - Return to IDLE when cur_note becomes a rest or ld_play==0; audio_out = 0 in the same cycle the condition is seen.
  - A repeated identical code across consecutive notes produces no restart.

Optional Feature:
- Macro NOTE_GAP_EN.
- Defined:
  - On any cur_note change while ld_play==1, including a change into the same pitch across a rest, enter GAP.
  - In GAP: audio_out = 0 for GAP_CYCLES cycles, then go to TONE for the new code if it is a pitch, or to IDLE if it is a rest.
  - ld_play falling during GAP goes to IDLE immediately.
- Undefined: GAP state and gap counter are not compiled; the new pitch starts in the cycle after cur_note changes.

Test Plan:
- Reset, then hold ld_note high 10 cycles with note_in=10 -> mem[0]=10, wr_ptr=1, only one write.
- 17 load pulses with note_in=1..15,1,2 -> mem_full=1 after the 16th pulse; mem[0]=2, wr_ptr=1 (wrapped).
- mem[3]=10, ld_play=1, note_counter=3 -> cur_note=10 one cycle later; audio_out toggles every 56818 cycles, period 113636.
- Rest code 0 at index 4, ld_play=1, note_counter steps 3->4 -> audio_out 0 within 2 cycles and stays 0; cur_note=0.
- ld_play 1->0 while audio_out=1 -> audio_out=0 next cycle; cur_note=0. Assert reset mid-tone -> all outputs 0 after the posedge.
- NOTE_GAP_EN with GAP_CYCLES=20, note change 1->5 -> audio_out 0 for 20 cycles, then toggles every 75843 cycles. Same test without the macro -> toggles immediately with no gap.
